lbp_hist: RTL and testbench

Histogram stage directly downstream of the LBP engine. It consumes the `lbp_valid`/`lbp_addr`/`lbp_data` write stream for the 128x128 image and accumulates a 256-bin histogram of LBP codes. When the engine raises `finish`, it streams the bins out over a valid/ready port. The downstream feature/compare logic uses this as the texture descriptor.

---
 rtl/lbp_pkg.sv | 27 ++
 rtl/hist_ram.sv | 25 ++
 rtl/lbp_hist.sv | 129 ++++++++++++
 tb/tb_lbp_hist.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP histogram stage: image geometry, bin count,
// histogram state encoding and the border-address test.
`timescale 1ns/1ps
package lbp_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int NBINS = 256;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hist_state_t;

  // Address layout is {row[6:0], col[6:0]}; the outermost ring carries no LBP code.
  function automatic logic is_border(input logic [13:0] addr);
    logic [6:0] row;
    logic [6:0] col;
    row = addr[13:7];
    col = addr[6:0];
    return (row == 7'd0) || (row == 7'(IMG_H - 1)) ||
           (col == 7'd0) || (col == 7'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/hist_ram.sv
// Histogram counter array: NBINS x CNT_W, one write port and one synchronous
// read port. A read of the address being written returns the old contents.
`timescale 1ns/1ps
module hist_ram
  import lbp_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [7:0]       raddr,
  output logic [CNT_W-1:0] rdata
);

  logic [CNT_W-1:0] mem [NBINS];

  // Write and registered read share the edge, so the read sees pre-write data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates a 256-bin histogram of LBP codes from the engine's
// write stream, then streams the bins out over a valid/ready port.
// Build option LBP_HIST_SAT_EN: bin counters saturate instead of wrapping.
`timescale 1ns/1ps
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic [13:0]      pix_total,
  output logic             addr_err
);

  function automatic logic [CNT_W-1:0] bin_inc(input logic [CNT_W-1:0] c);
`ifdef LBP_HIST_SAT_EN
    return (&c) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  hist_state_t      state_q, state_d;
  logic [NBINS-1:0] bin_vld;
  logic [CNT_W-1:0] rdata;
  logic [7:0]       raddr;

  logic             border_p0, accept_p0;
  logic             vld_p1, fwd_p1;
  logic [7:0]       bin_p1;
  logic [CNT_W-1:0] fwd_cnt_p1, cur_p1, wdata_p1;

  logic [8:0]       rd_ptr;
  logic             rvld_p1, skid_vld, skid_vld_d, skid_load, issue, pop;
  logic [7:0]       rbin_p1, skid_bin, out_bin;
  logic [CNT_W-1:0] skid_cnt, head_cnt, out_cnt;

  // ---- stage 0: border check, accept, read address ----
  assign border_p0 = is_border(lbp_addr);
  assign accept_p0 = (state_q == ACCUM) && lbp_valid && !border_p0;
  assign raddr     = (state_q == DRAIN) ? rd_ptr[7:0] : lbp_data;

  // ---- stage 1: old count (forwarded if just written) plus one ----
  assign cur_p1   = fwd_p1 ? fwd_cnt_p1 : (bin_vld[bin_p1] ? rdata : '0);
  assign wdata_p1 = bin_inc(cur_p1);

  hist_ram #(.CNT_W(CNT_W)) u_ram (
    .clk   (clk),
    .we    (vld_p1),
    .waddr (bin_p1),
    .wdata (wdata_p1),
    .raddr (raddr),
    .rdata (rdata)
  );

  // ---- drain: RAM output is the head entry, skid holds one bin under back-pressure ----
  assign head_cnt   = bin_vld[rbin_p1] ? rdata : '0;
  assign out_bin    = skid_vld ? skid_bin : rbin_p1;
  assign out_cnt    = skid_vld ? skid_cnt : head_cnt;
  assign hist_valid = skid_vld | rvld_p1;
  assign hist_bin   = hist_valid ? out_bin : '0;
  assign hist_count = hist_valid ? out_cnt : '0;
  assign hist_done  = (state_q == DONE);
  assign pop        = hist_valid && hist_ready;
  // An unconsumed head moves into the skid; a read is issued only when the skid
  // will be empty next cycle, so the returning data always has a place to land.
  assign skid_vld_d = skid_vld ? (pop ? rvld_p1 : 1'b1) : (rvld_p1 && !pop);
  assign skid_load  = rvld_p1 && (skid_vld ? pop : !pop);
  assign issue      = (state_q == DRAIN) && !rd_ptr[8] && !skid_vld_d;

  // Next-state decode for the accumulate/flush/drain/done sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (finish) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (pop && (out_bin == 8'hFF)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase
  end

  // Control state: FSM, per-bin valid bits, pipeline valids, status counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ACCUM;
      bin_vld   <= '0;
      vld_p1    <= 1'b0;
      fwd_p1    <= 1'b0;
      pix_total <= '0;
      addr_err  <= 1'b0;
      rd_ptr    <= '0;
      rvld_p1   <= 1'b0;
      skid_vld  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_p1   <= accept_p0;
      fwd_p1   <= accept_p0 && vld_p1 && (bin_p1 == lbp_data);
      if (vld_p1) bin_vld[bin_p1] <= 1'b1;
      if (accept_p0) pix_total <= pix_total + 14'd1;
      if ((state_q == ACCUM) && lbp_valid && border_p0) addr_err <= 1'b1;
      rvld_p1  <= issue;
      if (issue) rd_ptr <= rd_ptr + 9'd1;
      skid_vld <= skid_vld_d;
    end
  end

  // Datapath registers; qualified by the valids above so they need no reset.
  always_ff @(posedge clk) begin
    bin_p1     <= lbp_data;
    fwd_cnt_p1 <= wdata_p1;
    if (issue) rbin_p1 <= rd_ptr[7:0];
    if (skid_load) begin
      skid_bin <= rbin_p1;
      skid_cnt <= head_cnt;
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: a CNT_W=14 instance and a CNT_W=2 instance are
// driven in lockstep from the same stimulus.
`timescale 1ns/1ps
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset, lbp_valid, finish, hist_ready;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;

  logic        hist_valid, hist_done, addr_err;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count, pix_total;

  logic        v2, d2, e2;
  logic [7:0]  b2;
  logic [1:0]  c2;
  logic [13:0] p2;

  int checks = 0;
  int errors = 0;
  int exp_a [256];
  int exp_b [256];

  always #5 clk = ~clk;

  lbp_hist #(.CNT_W(14)) dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
    .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
    .hist_done(hist_done), .pix_total(pix_total), .addr_err(addr_err)
  );

  lbp_hist #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(v2),
    .hist_ready(hist_ready), .hist_bin(b2), .hist_count(c2),
    .hist_done(d2), .pix_total(p2), .addr_err(e2)
  );

  // Expected count of a 2-bit counter after n increments.
  function automatic int m2(input int n);
`ifdef LBP_HIST_SAT_EN
    return (n > 3) ? 3 : n;
`else
    return n % 4;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 256; i++) begin
      exp_a[i] = 0;
      exp_b[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    lbp_valid = 1'b0;
    finish = 1'b0;
    hist_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [6:0] r, input logic [6:0] c, input logic [7:0] code);
    lbp_valid = 1'b1;
    lbp_addr  = {r, c};
    lbp_data  = code;
    tick();
    lbp_valid = 1'b0;
  endtask

  // Collect all 256 bins; bp selects a 1-0-0-1 ready pattern instead of always-ready.
  task automatic drain(input bit bp, input string tag);
    int got, cyc;
    bit stalled;
    logic [7:0]  sb;
    logic [13:0] sc;
    got = 0; cyc = 0; stalled = 1'b0; sb = '0; sc = '0;
    while (got < 256 && cyc < 2000) begin
      hist_ready = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (stalled) begin
        chk({tag, "_hold_valid"}, int'(hist_valid), 1);
        chk({tag, "_hold_bin"}, int'(hist_bin), int'(sb));
        chk({tag, "_hold_count"}, int'(hist_count), int'(sc));
      end
      stalled = 1'b0;
      if (hist_valid) begin
        if (hist_ready) begin
          chk({tag, "_bin"}, int'(hist_bin), got);
          chk({tag, "_count"}, int'(hist_count), exp_a[got]);
          chk({tag, "_bin2"}, int'(b2), got);
          chk({tag, "_count2"}, int'(c2), exp_b[got]);
          if (got == 255) chk({tag, "_done_early"}, int'(hist_done), 0);
          got++;
        end else begin
          stalled = 1'b1;
          sb = hist_bin;
          sc = hist_count;
        end
      end
      tick();
      cyc++;
    end
    hist_ready = 1'b0;
    chk({tag, "_transfers"}, got, 256);
    chk({tag, "_done"}, int'(hist_done), 1);
    chk({tag, "_done2"}, int'(d2), 1);
    chk({tag, "_valid_after"}, int'(hist_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; hist_ready = 1'b0;
    #1;
    chk("rst_valid", int'(hist_valid), 0);
    chk("rst_bin", int'(hist_bin), 0);
    chk("rst_count", int'(hist_count), 0);
    chk("rst_done", int'(hist_done), 0);
    chk("rst_pix", int'(pix_total), 0);
    chk("rst_err", int'(addr_err), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Back-to-back identical codes exercise the write-to-read forwarding path.
    clr_exp();
    repeat (5) feed(7'd5, 7'd5, 8'h3C);
    repeat (5) feed(7'd6, 7'd9, 8'h10);
    exp_a[8'h3C] = 5; exp_a[8'h10] = 5;
    exp_b[8'h3C] = m2(5); exp_b[8'h10] = m2(5);
    chk("b2b_pix", int'(pix_total), 10);
    chk("b2b_pix2", int'(p2), 10);
    chk("b2b_err", int'(addr_err), 0);
    finish = 1'b1;
    tick();
    chk("lat_t1", int'(hist_valid), 0);
    tick();
    chk("lat_t2", int'(hist_valid), 0);
    tick();
    chk("lat_t3", int'(hist_valid), 1);
    drain(1'b0, "b2b");

    // Border addresses, finish coinciding with a sample, late sample ignored.
    do_reset();
    clr_exp();
    feed(7'd0, 7'd5, 8'h01);
    chk("border_err", int'(addr_err), 1);
    chk("border_err2", int'(e2), 1);
    chk("border_pix", int'(pix_total), 0);
    feed(7'd127, 7'd20, 8'h01);
    feed(7'd30, 7'd0, 8'h01);
    feed(7'd30, 7'd127, 8'h01);
    chk("border_pix_all", int'(pix_total), 0);
    finish = 1'b1;
    feed(7'd40, 7'd40, 8'hFF);
    chk("fin_lat_t1", int'(hist_valid), 0);
    tick();
    feed(7'd41, 7'd41, 8'hFF);
    chk("fin_lat_t3", int'(hist_valid), 1);
    exp_a[8'hFF] = 1; exp_b[8'hFF] = 1;
    drain(1'b1, "bp");
    chk("fin_pix", int'(pix_total), 1);
    chk("fin_err_sticky", int'(addr_err), 1);

    // Reset in the middle of draining, then a clean empty run.
    do_reset();
    clr_exp();
    repeat (3) feed(7'd3, 7'd3, 8'h22);
    finish = 1'b1;
    hist_ready = 1'b1;
    repeat (12) tick();
    chk("mid_valid_pre", int'(hist_valid), 1);
    reset = 1'b0;
    #1;
    chk("mid_valid", int'(hist_valid), 0);
    chk("mid_valid2", int'(v2), 0);
    chk("mid_count", int'(hist_count), 0);
    chk("mid_done", int'(hist_done), 0);
    chk("mid_pix", int'(pix_total), 0);
    hist_ready = 1'b0;
    finish = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    finish = 1'b1;
    drain(1'b0, "rerun");

    // Full interior image with code = column index.
    do_reset();
    clr_exp();
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        feed(7'(r), 7'(c), 8'(c));
      end
    end
    for (int c = 1; c <= 126; c++) begin
      exp_a[c] = 126;
      exp_b[c] = m2(126);
    end
    tick();
    chk("full_pix", int'(pix_total), 15876);
    chk("full_pix2", int'(p2), 15876);
    chk("full_err", int'(addr_err), 0);
    finish = 1'b1;
    drain(1'b0, "full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
